// File: rtl/aes_pkg.sv
// Shared AES state geometry: row-major 128-bit state, 4 rows of 4 bytes.
// Latency: none (types, constants and a constant-foldable helper only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NB      = 4;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } sr_state_t;

    // MSB index of byte (row, col); use as state[byte_pos(r, c) -: AES_BYTE_W].
    function automatic int byte_pos(input int row, input int col);
        return AES_STATE_W - 1 - (AES_NB * AES_BYTE_W * row) - (AES_BYTE_W * col);
    endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows byte permutation of one AES state.
// Latency: 0 cycles (pure wiring plus a 2:1 mux per byte).
// Backpressure: none, no handshake.
module shift_rows_core
    import aes_pkg::*;
(
    input  aes_state_t state_in,
    input  logic       inv,
    output aes_state_t state_out
);

    for (genvar r = 0; r < AES_NB; r++) begin : g_row
        for (genvar c = 0; c < AES_NB; c++) begin : g_col
            localparam int DST = byte_pos(r, c);
            localparam int FWD = byte_pos(r, (c + r) % AES_NB);
            localparam int INV = byte_pos(r, (c - r + AES_NB) % AES_NB);
            assign state_out[DST -: AES_BYTE_W] = inv ? state_in[INV -: AES_BYTE_W]
                                                      : state_in[FWD -: AES_BYTE_W];
        end
    end

endmodule

// File: rtl/shift_rows_serial.sv
// Byte-serial ShiftRows: packs 16 bytes into a state, emits the permuted state (inverse via SHIFT_ROWS_SERIAL_INV_EN).
// Latency: result registered 1 cycle after the 16th byte is accepted; 1 byte/cycle sustained.
// Backpressure: a full block waits (in_ready low) while the output register is still held.
module shift_rows_serial
    import aes_pkg::*;
#(
    parameter int BLK_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
`ifdef SHIFT_ROWS_SERIAL_INV_EN
    input  logic                 inv,
`endif
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [127:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLK_CNT_W-1:0] blk_cnt
);

    sr_state_t  state_q, state_n;
    logic [3:0] cnt_q, cnt_n;
    aes_state_t blk_q, blk_n;
    aes_state_t core_out;
    logic       core_inv;
    logic       load;
    logic       drain;

    assign drain = out_valid & out_ready;

`ifdef SHIFT_ROWS_SERIAL_INV_EN
    logic inv_q;

    // Direction is latched with the first byte so it stays fixed for the whole block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state_q == FILL && !clr && in_valid && cnt_q == 4'd0) begin
            inv_q <= inv;
        end
    end

    assign core_inv = inv_q;
`else
    assign core_inv = 1'b0;
`endif

    // blk_n already holds the incoming 16th byte, so the core sees the full block at once.
    shift_rows_core u_core (
        .state_in  (blk_n),
        .inv       (core_inv),
        .state_out (core_out)
    );

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        blk_n    = blk_q;
        in_ready = 1'b0;
        load     = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = !clr;
                if (clr) begin
                    cnt_n = 4'd0;
                end else if (in_valid) begin
                    for (int k = 0; k < 16; k++) begin
                        if (cnt_q == 4'(k)) begin
                            blk_n[byte_pos(k / AES_NB, k % AES_NB) -: AES_BYTE_W] = in_byte;
                        end
                    end
                    cnt_n = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (!out_valid || out_ready) begin
                            load = 1'b1;
                        end else begin
                            state_n = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (clr) begin
                    state_n = FILL;
                end else if (drain) begin
                    load    = 1'b1;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= 4'd0;
            blk_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            blk_q   <= blk_n;
            if (load) begin
                out_data  <= core_out;
                out_valid <= 1'b1;
                blk_cnt   <= blk_cnt + BLK_CNT_W'(1);
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_serial.sv
// Self-checking bench for shift_rows_serial: directed scenarios plus randomized traffic
// scored against a block-level model (byte list -> permuted state, two-deep output queue).
module tb_shift_rows_serial;

    localparam int CNT_W = 2;
    localparam logic [127:0] C1 = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
    localparam logic [127:0] C2 = 128'h10111213_15161714_1A1B1819_1F1C1D1E;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [127:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] blk_cnt;
`ifdef SHIFT_ROWS_SERIAL_INV_EN
    logic             inv = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    shift_rows_serial #(.BLK_CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
`ifdef SHIFT_ROWS_SERIAL_INV_EN
        .inv       (inv),
`endif
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: byte k sits at row k/4, column k%4; row r rotates left by r (right by r when inverse).
    function automatic logic [127:0] ref_rows(input logic [7:0] b[16], input bit inv_m);
        logic [127:0] r;
        int src;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                src = inv_m ? (col - row + 4) % 4 : (col + row) % 4;
                r[127 - 8 * (4 * row + col) -: 8] = b[4 * row + src];
            end
        end
        return r;
    endfunction

    // Model: exp_q[0] is the word in the output register, exp_q[1] a completed block held back.
    logic [7:0]   partial[$];
    logic [127:0] exp_q[$];
    int           consumed = 0;
    bit           part_inv = 1'b0;

    always @(negedge clk) begin
        logic [7:0] blk[16];
        bit waiting;
        bit exp_ready;
        if (rst) begin
            partial.delete();
            exp_q.delete();
            consumed = 0;
        end else begin
            exp_ready = !clr && exp_q.size() < 2;
            check("in_ready", 128'(in_ready), 128'(exp_ready));
            check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            check("blk_cnt", 128'(blk_cnt), 128'((consumed + (exp_q.size() > 0 ? 1 : 0)) % 4));
            if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
            waiting = exp_q.size() == 2;
            if (exp_q.size() > 0 && out_ready) begin
                void'(exp_q.pop_front());
                consumed++;
            end
            if (clr) begin
                partial.delete();
                if (waiting) void'(exp_q.pop_back());
            end else if (in_valid && exp_ready) begin
`ifdef SHIFT_ROWS_SERIAL_INV_EN
                if (partial.size() == 0) part_inv = inv;
`endif
                partial.push_back(in_byte);
                if (partial.size() == 16) begin
                    for (int k = 0; k < 16; k++) blk[k] = partial[k];
                    exp_q.push_back(ref_rows(blk, part_inv));
                    partial.delete();
                end
            end
        end
    end

    // Offers one byte until accepted; optionally reshuffles out_ready while stalled.
    task automatic send_byte(input logic [7:0] b, input bit rnd_ready);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else if (t > 200) begin
                check("send_timeout", 128'(in_ready), 128'(1));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            t++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) send_byte(base + 8'(k), 1'b0);
    endtask

    initial begin
        logic [127:0] c1_bytes;
        int t;

        // Reset state
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Back-to-back block, consumer always ready
        out_ready = 1'b1;
        send_seq(8'h00, 16);
        check("s1_valid", 128'(out_valid), 128'(1));
        check("s1_data", out_data, C1);
        check("s1_cnt", 128'(blk_cnt), 128'(1));
        @(posedge clk);
        #1;

        // Two blocks against a stalled consumer
        out_ready = 1'b0;
        send_seq(8'h00, 32);
        check("s2_wait_ready", 128'(in_ready), 128'(0));
        check("s2_hold_data", out_data, C1);
        check("s2_cnt", 128'(blk_cnt), 128'(2));
        repeat (8) @(posedge clk);
        #1;
        check("s2_stable_data", out_data, C1);
        check("s2_stable_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("s2_data2", out_data, C2);
        check("s2_ready_back", 128'(in_ready), 128'(1));
        check("s2_cnt2", 128'(blk_cnt), 128'(3));
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Partial block discarded by clr; the byte offered alongside clr is refused
        send_seq(8'h50, 7);
        clr = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'hAA;
        #2 check("clr_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        send_seq(8'h00, 16);
        check("s3_data", out_data, C1);
        check("s3_cnt_wrap", 128'(blk_cnt), 128'(0));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a block
        send_seq(8'h00, 9);
        #2 rst = 1'b1;
        #1;
        check("s4_rst_valid", 128'(out_valid), 128'(0));
        check("s4_rst_cnt", 128'(blk_cnt), 128'(0));
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        send_seq(8'h00, 16);
        check("s4_data", out_data, C1);
        check("s4_cnt", 128'(blk_cnt), 128'(1));

        // Five random blocks with random consumer stalls; blk_cnt must walk 1,2,3,0,1
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 16; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                send_byte(8'($urandom), 1'b1);
            end
            t = 0;
            while (blk_cnt != 2'((b + 1) % 4) && t < 50) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
                t++;
            end
            check("blk_seq", 128'(blk_cnt), 128'((b + 1) % 4));
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

`ifdef SHIFT_ROWS_SERIAL_INV_EN
        // Inverse direction undoes the forward permutation
        c1_bytes = C1;
        for (int k = 0; k < 16; k++) begin
            inv = (k == 0);
            send_byte(c1_bytes[127 - 8 * k -: 8], 1'b0);
        end
        inv = 1'b0;
        check("inv_data", out_data, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        @(posedge clk);
        #1;
`else
        c1_bytes = '0;
`endif

        // Random soak with clr pulses and stalls; model checks run every cycle
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 39) == 0);
`ifdef SHIFT_ROWS_SERIAL_INV_EN
            inv       = 1'($urandom_range(0, 1));
`endif
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("final_drain", 128'(out_valid), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
